program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, width of instruction-memory byte address.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, width of word-count input.
REQ-003 clock_in  input  1  single clock for all state; also drives the instruction-memory write clock at top level.
REQ-004 reset_in  input  1  asynchronous, active-high reset.
REQ-005 start_in  input  1  one-cycle request to begin a load; sampled only in IDLE, DONE, ERROR.
REQ-006 base_address_in  input  ADDRESS_WIDTH  byte address of first word; sampled on accepted start.
REQ-007 word_count_in  input  COUNT_WIDTH  number of 32-bit words to load; sampled on accepted start.
REQ-008 byte_valid_in / byte_in  input  1 / 8  host byte stream.
REQ-009 byte_ready_out  output  1  loader accepts byte_in this cycle.
REQ-010 instr_write_out / instr_address_out / instr_data_out  output  1 / ADDRESS_WIDTH / 32  instruction-memory write port (word mode).
REQ-011 read_instr_in  input  32  instruction-memory readback data for instr_address_out.
REQ-012 cpu_reset_out  output  1  holds processor in reset while not DONE.
REQ-013 busy_out / done_out / error_out  output  1 each  status.
REQ-014 error_address_out  output  ADDRESS_WIDTH  address of first failed readback.

Function
REQ-015 SHALL implement FSM states IDLE, COLLECT, WRITE, READBACK, CHECK, DONE, ERROR.
REQ-016 IDLE/DONE/ERROR + start_in: latch base, count; clear word counter, byte index; go COLLECT, or DONE next cycle if word_count_in = 0.
REQ-017 COLLECT: byte_ready_out = 1; byte accepted when byte_valid_in & byte_ready_out; byte k (0..3) placed in bits [8k+7:8k] (little-endian).
REQ-018 After 4th accepted byte, go WRITE next cycle; byte_ready_out = 0 in all states except COLLECT.
REQ-019 WRITE: instr_write_out = 1 for exactly one cycle, address and data stable; go READBACK.
REQ-020 READBACK: write deasserted, address held one wait cycle; go CHECK.
REQ-021 CHECK: read_instr_in = assembled word -> word counter +1, address +4; go DONE if counter = count, else COLLECT.
REQ-022 CHECK mismatch: latch error_address_out = current address; go ERROR.
REQ-023 Minimum per-word latency 7 cycles (4 COLLECT + WRITE + READBACK + CHECK); byte_valid_in gaps stall COLLECT only.
REQ-024 Address increment SHALL wrap modulo 2^ADDRESS_WIDTH.
REQ-025 busy_out = 1 in COLLECT, WRITE, READBACK, CHECK; start_in ignored while busy.
REQ-026 DONE: done_out = 1, cpu_reset_out = 0; ERROR: error_out = 1, cpu_reset_out = 1.
REQ-027 New start from DONE SHALL reassert cpu_reset_out in the cycle after start is accepted; new start clears error_out, done_out.
REQ-028 instr_write_out SHALL never be asserted outside WRITE.

Reset
REQ-029 reset_in SHALL force IDLE immediately: cpu_reset_out = 1; all other outputs, counters, byte index, assembled word, error_address_out = 0.
REQ-030 Reset mid-load SHALL abort without further write; partially assembled word discarded.

Structure
REQ-031 State enum and BYTES_PER_WORD = 4 SHALL live in shared package loader_pkg.
REQ-032 Byte assembly SHALL be sub-module byte_to_word (index counter, word register, word_valid pulse).

Verification
REQ-033 start, base 0x0, count 2, bytes 13 00 08 20 / 2A 00 09 20, ideal readback -> writes 0x20080013 @0x0, 0x2009002A @0x4; done_out after 14 cycles; cpu_reset_out falls.
REQ-034 count 0 -> done_out next cycle, no instr_write_out pulse.
REQ-035 readback of word 1 forced to 0xDEADBEEF, base 0x100 -> error_out = 1, error_address_out = 0x104, cpu_reset_out stays 1.
REQ-036 byte_valid_in toggled 1/0 each cycle -> same written words; per-word latency 10 cycles.
REQ-037 base 0xFFFFFFFC, count 2 -> second write at 0x00000000.
REQ-038 reset_in asserted after 2 bytes of word 0 -> IDLE, no write; subsequent start loads correctly.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: shared FSM state encoding and word geometry for the program loader
package loader_pkg;
    localparam int BYTES_PER_WORD = 4;
    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, READBACK, CHECK, DONE, ERROR} state_t;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: host byte stream plus instruction-memory write/readback port
interface program_loader_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic                     byte_valid_in;
    logic [7:0]               byte_in;
    logic                     byte_ready_out;
    logic                     instr_write_out;
    logic [ADDRESS_WIDTH-1:0] instr_address_out;
    logic [31:0]              instr_data_out;
    logic [31:0]              read_instr_in;
    modport slave (
        input  byte_valid_in, byte_in, read_instr_in,
        output byte_ready_out, instr_write_out, instr_address_out, instr_data_out
    );
    modport master (
        output byte_valid_in, byte_in, read_instr_in,
        input  byte_ready_out, instr_write_out, instr_address_out, instr_data_out
    );
endinterface

// File: rtl/byte_to_word.sv
// byte_to_word: packs accepted bytes little-endian into a word, pulsing word_valid on the last byte
module byte_to_word
    import loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        byte_valid,
    input  logic [7:0]                  byte_data,
    output logic [8*BYTES_PER_WORD-1:0] word,
    output logic                        word_valid
);
    localparam int IW = $clog2(BYTES_PER_WORD);
    logic [IW-1:0] idx;
    assign word_valid = byte_valid && idx == IW'(BYTES_PER_WORD - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= '0;
            word <= '0;
        end else if (clear) begin
            idx  <= '0;
            word <= '0;
        end else if (byte_valid) begin
            word[{idx, 3'b000} +: 8] <= byte_data;
            idx <= word_valid ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: streams host bytes into instruction memory word by word,
// verifies each write by readback and releases the CPU only after a clean load.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic                     start_in,
    input  logic [ADDRESS_WIDTH-1:0] base_address_in,
    input  logic [COUNT_WIDTH-1:0]   word_count_in,
    program_loader_if.slave          bus,
    output logic                     cpu_reset_out,
    output logic                     busy_out,
    output logic                     done_out,
    output logic                     error_out,
    output logic [ADDRESS_WIDTH-1:0] error_address_out
);
    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [COUNT_WIDTH-1:0]   count;
    logic [COUNT_WIDTH-1:0]   words;
    logic [31:0]              word;
    logic                     word_valid;
    logic                     start_ok;
    logic                     accept;
    logic                     match;
    assign start_ok = start_in && (state == IDLE || state == DONE || state == ERROR);
    assign accept   = bus.byte_valid_in && bus.byte_ready_out;
    assign match    = bus.read_instr_in == word;
    assign bus.byte_ready_out    = state == COLLECT;
    assign bus.instr_write_out   = state == WRITE;
    assign bus.instr_address_out = addr;
    assign bus.instr_data_out    = word;
    assign busy_out      = state == COLLECT || state == WRITE || state == READBACK || state == CHECK;
    assign done_out      = state == DONE;
    assign error_out     = state == ERROR;
    assign cpu_reset_out = state != DONE;
    byte_to_word u_pack (
        .clk        (clock_in),
        .rst        (reset_in),
        .clear      (start_ok),
        .byte_valid (accept),
        .byte_data  (bus.byte_in),
        .word       (word),
        .word_valid (word_valid)
    );
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state             <= IDLE;
            addr              <= '0;
            count             <= '0;
            words             <= '0;
            error_address_out <= '0;
        end else if (start_ok) begin
            addr  <= base_address_in;
            count <= word_count_in;
            words <= '0;
            state <= word_count_in == '0 ? DONE : COLLECT;
        end else begin
            case (state)
                COLLECT:  if (word_valid) state <= WRITE;
                WRITE:    state <= READBACK;
                READBACK: state <= CHECK;
                CHECK: begin
                    if (match) begin
                        words <= words + COUNT_WIDTH'(1);
                        addr  <= addr + ADDRESS_WIDTH'(4);
                        state <= words + COUNT_WIDTH'(1) == count ? DONE : COLLECT;
                    end else begin
                        error_address_out <= addr;
                        state             <= ERROR;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed scenarios against a readback memory model of the instruction store
module tb_program_loader;
    logic        clk = 1'b0;
    logic        reset_in;
    logic        start_in = 1'b0;
    logic [31:0] base_address_in = '0;
    logic [15:0] word_count_in = '0;
    logic        cpu_reset_out, busy_out, done_out, error_out;
    logic [31:0] error_address_out;
    logic [31:0] last_data = '0;
    logic        corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = '0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [7:0]  q[$];
    int total = 0;
    int bad = 0;
    int cyc;

    program_loader_if #(.ADDRESS_WIDTH(32)) bus ();

    program_loader #(.ADDRESS_WIDTH(32), .COUNT_WIDTH(16)) dut (
        .clock_in          (clk),
        .reset_in          (reset_in),
        .start_in          (start_in),
        .base_address_in   (base_address_in),
        .word_count_in     (word_count_in),
        .bus               (bus),
        .cpu_reset_out     (cpu_reset_out),
        .busy_out          (busy_out),
        .done_out          (done_out),
        .error_out         (error_out),
        .error_address_out (error_address_out)
    );

    always #5 clk = ~clk;

    assign bus.read_instr_in = (corrupt_en && bus.instr_address_out == corrupt_addr) ? 32'hDEADBEEF : last_data;

    always @(posedge clk) begin
        if (bus.instr_write_out) begin
            wa.push_back(bus.instr_address_out);
            wd.push_back(bus.instr_data_out);
            last_data <= bus.instr_data_out;
        end
    end

    task automatic start(input logic [31:0] base, input logic [15:0] n);
        start_in = 1'b1;
        base_address_in = base;
        word_count_in = n;
        @(negedge clk);
        start_in = 1'b0;
    endtask

    // Feeds queued bytes one per cycle (or every other cycle with gaps) until done/error or budget.
    task automatic run(input int max_cycles, input bit gaps, output int cycles);
        bit ph = 1'b1;
        cycles = 0;
        while (!(done_out || error_out) && cycles < max_cycles) begin
            bus.byte_valid_in = q.size() > 0 && (!gaps || ph);
            bus.byte_in = q.size() > 0 ? q[0] : 8'h00;
            if (bus.byte_valid_in && bus.byte_ready_out) void'(q.pop_front());
            @(negedge clk);
            cycles++;
            ph = !ph;
        end
        bus.byte_valid_in = 1'b0;
    endtask

    task automatic test_reset;
        reset_in = 1'b1;
        bus.byte_valid_in = 1'b0;
        bus.byte_in = 8'h00;
        repeat (2) @(negedge clk);
        total++; if (cpu_reset_out !== 1'b1) begin bad++; $display("FAIL reset_cpu_reset got %b exp 1", cpu_reset_out); end
        total++; if ({busy_out, done_out, error_out} !== 3'b000) begin bad++; $display("FAIL reset_status got %b exp 000", {busy_out, done_out, error_out}); end
        total++; if ({bus.instr_write_out, bus.byte_ready_out} !== 2'b00) begin bad++; $display("FAIL reset_write_ready got %b exp 00", {bus.instr_write_out, bus.byte_ready_out}); end
        total++; if (bus.instr_address_out !== 32'h0 || bus.instr_data_out !== 32'h0 || error_address_out !== 32'h0) begin bad++; $display("FAIL reset_regs got addr %h data %h erraddr %h exp 0", bus.instr_address_out, bus.instr_data_out, error_address_out); end
        reset_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_two_words;
        wa.delete(); wd.delete();
        q = '{8'h13, 8'h00, 8'h08, 8'h20, 8'h2A, 8'h00, 8'h09, 8'h20};
        start(32'h0, 16'd2);
        total++; if (busy_out !== 1'b1 || bus.byte_ready_out !== 1'b1) begin bad++; $display("FAIL two_busy got %b%b exp 11", busy_out, bus.byte_ready_out); end
        run(100, 1'b0, cyc);
        total++; if (done_out !== 1'b1 || cyc != 14) begin bad++; $display("FAIL two_latency got done %b cycles %0d exp 1 14", done_out, cyc); end
        total++; if (cpu_reset_out !== 1'b0 || busy_out !== 1'b0) begin bad++; $display("FAIL two_release got cpu_reset %b busy %b exp 0 0", cpu_reset_out, busy_out); end
        total++; if (wa.size() != 2) begin bad++; $display("FAIL two_nwrites got %0d exp 2", wa.size()); end
        total++; if (wa[0] !== 32'h0 || wd[0] !== 32'h20080013) begin bad++; $display("FAIL two_w0 got %h@%h exp 20080013@00000000", wd[0], wa[0]); end
        total++; if (wa[1] !== 32'h4 || wd[1] !== 32'h2009002A) begin bad++; $display("FAIL two_w1 got %h@%h exp 2009002a@00000004", wd[1], wa[1]); end
    endtask

    task automatic test_back_to_back;
        wa.delete(); wd.delete();
        q = '{8'h13, 8'h00, 8'h08, 8'h20, 8'h2A, 8'h00, 8'h09, 8'h20};
        start(32'h200, 16'd2);
        total++; if (cpu_reset_out !== 1'b1 || done_out !== 1'b0) begin bad++; $display("FAIL restart_cpu_reset got cpu_reset %b done %b exp 1 0", cpu_reset_out, done_out); end
        run(100, 1'b1, cyc);
        total++; if (done_out !== 1'b1 || cyc != 20) begin bad++; $display("FAIL gaps_latency got done %b cycles %0d exp 1 20", done_out, cyc); end
        total++; if (wa.size() != 2 || wd[0] !== 32'h20080013 || wd[1] !== 32'h2009002A) begin bad++; $display("FAIL gaps_data got n %0d %h %h exp 2 20080013 2009002a", wa.size(), wd[0], wd[1]); end
        total++; if (wa[0] !== 32'h200 || wa[1] !== 32'h204) begin bad++; $display("FAIL gaps_addr got %h %h exp 00000200 00000204", wa[0], wa[1]); end
    endtask

    task automatic test_error;
        wa.delete(); wd.delete();
        corrupt_en = 1'b1;
        corrupt_addr = 32'h104;
        q = '{8'h13, 8'h00, 8'h08, 8'h20, 8'h2A, 8'h00, 8'h09, 8'h20};
        start(32'h100, 16'd2);
        run(100, 1'b0, cyc);
        total++; if (error_out !== 1'b1 || done_out !== 1'b0 || cyc != 14) begin bad++; $display("FAIL err_state got err %b done %b cycles %0d exp 1 0 14", error_out, done_out, cyc); end
        total++; if (error_address_out !== 32'h104) begin bad++; $display("FAIL err_addr got %h exp 00000104", error_address_out); end
        total++; if (cpu_reset_out !== 1'b1 || busy_out !== 1'b0) begin bad++; $display("FAIL err_cpu_reset got cpu_reset %b busy %b exp 1 0", cpu_reset_out, busy_out); end
        total++; if (wa.size() != 2) begin bad++; $display("FAIL err_nwrites got %0d exp 2", wa.size()); end
        corrupt_en = 1'b0;
    endtask

    task automatic test_zero_count;
        wa.delete(); wd.delete();
        start(32'h80, 16'd0);
        total++; if (done_out !== 1'b1 || error_out !== 1'b0) begin bad++; $display("FAIL zero_done got done %b err %b exp 1 0", done_out, error_out); end
        total++; if (cpu_reset_out !== 1'b0 || busy_out !== 1'b0) begin bad++; $display("FAIL zero_release got cpu_reset %b busy %b exp 0 0", cpu_reset_out, busy_out); end
        repeat (3) @(negedge clk);
        total++; if (wa.size() != 0) begin bad++; $display("FAIL zero_nwrites got %0d exp 0", wa.size()); end
    endtask

    task automatic test_wrap;
        wa.delete(); wd.delete();
        q = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
        start(32'hFFFFFFFC, 16'd2);
        run(100, 1'b0, cyc);
        total++; if (done_out !== 1'b1 || wa.size() != 2) begin bad++; $display("FAIL wrap_done got done %b n %0d exp 1 2", done_out, wa.size()); end
        total++; if (wa[0] !== 32'hFFFFFFFC || wa[1] !== 32'h0) begin bad++; $display("FAIL wrap_addr got %h %h exp fffffffc 00000000", wa[0], wa[1]); end
        total++; if (wd[0] !== 32'h11223344 || wd[1] !== 32'h55667788) begin bad++; $display("FAIL wrap_data got %h %h exp 11223344 55667788", wd[0], wd[1]); end
    endtask

    task automatic test_reset_mid;
        wa.delete(); wd.delete();
        q = '{8'h13, 8'h00};
        start(32'h40, 16'd1);
        run(2, 1'b0, cyc);
        reset_in = 1'b1;
        #1;
        total++; if (busy_out !== 1'b0 || cpu_reset_out !== 1'b1 || done_out !== 1'b0) begin bad++; $display("FAIL mid_reset got busy %b cpu_reset %b done %b exp 0 1 0", busy_out, cpu_reset_out, done_out); end
        total++; if (error_address_out !== 32'h0 || bus.instr_data_out !== 32'h0) begin bad++; $display("FAIL mid_clear got erraddr %h data %h exp 0 0", error_address_out, bus.instr_data_out); end
        @(negedge clk);
        reset_in = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (wa.size() != 0) begin bad++; $display("FAIL mid_nowrite got %0d exp 0", wa.size()); end
        q = '{8'h2A, 8'h00, 8'h09, 8'h20};
        start(32'h40, 16'd1);
        run(100, 1'b0, cyc);
        total++; if (done_out !== 1'b1 || cyc != 7) begin bad++; $display("FAIL mid_reload got done %b cycles %0d exp 1 7", done_out, cyc); end
        total++; if (wa.size() != 1 || wa[0] !== 32'h40 || wd[0] !== 32'h2009002A) begin bad++; $display("FAIL mid_word got n %0d %h@%h exp 1 2009002a@00000040", wa.size(), wd[0], wa[0]); end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_back_to_back();
        test_error();
        test_zero_count();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
